cmd_read: RTL and testbench
===========================

Name: cmd_read

Overview:
Receives SD card responses on the CMD line. It is the stage directly downstream of the command transmitter. Once the command's end bit has gone out, it is armed by the controller FSM, waits up to a bounded number of SD clock cycles for a start bit, then shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. It checks the CRC7, end bit and command index, and presents the payload and error flags to the SDHCI response/interrupt registers.

Parameters:
TimeoutCycles, 64, SD clock cycles allowed between arming and start bit (NCR) before timeout.

Ports:
clk_i  in  1  system clock; single clock domain.
rst_ni  in  1  reset; synchronous, active-low.
clk_en_p_i  in  1  one-cycle enable marking the SD clock rising edge; CMD is sampled only here.
cmd_i  in  1  CMD line input, already synchronised.
start_rx_i  in  1  arm receiver; accepted only in IDLE.
long_rsp_i  in  1  1 = 136-bit R2, 0 = 48-bit; latched at arm.
check_crc_i  in  1  enable CRC7 check (0 for R3); latched at arm.
check_idx_i  in  1  enable index check; latched at arm.
cmd_nr_i  in  6  expected command index; latched at arm.
rsp_o  out  120  response payload (see Behaviour); holds until next arm.
rx_done_o  out  1  one-cycle pulse when reception ends (success or error).
busy_o  out  1  high from arm until the rx_done_o pulse.
timeout_err_o  out  1  no start bit within TimeoutCycles.
crc_err_o  out  1  CRC7 mismatch.
end_bit_err_o  out  1  end bit sampled 0.
index_err_o  out  1  received index differs from cmd_nr_i.

Behaviour:
- Reset: state IDLE; rsp_o = 0; all error outputs 0; rx_done_o = 0; busy_o = 0.
- Reset applied mid-reception aborts it without a rx_done_o pulse.
- FSM: IDLE, WAIT_START, RECEIVE, CHECK.
- IDLE → WAIT_START on start_rx_i; same cycle: latch config, clear error flags, clear bit and timeout counters, busy_o = 1.
- WAIT_START, each clk_en_p_i tick:
  - cmd_i == 0: go to RECEIVE with bit counter = 1 (start bit consumed).
  - otherwise increment the timeout counter; when it reaches TimeoutCycles: set timeout_err_o, pulse rx_done_o, go to IDLE.
- RECEIVE, each clk_en_p_i tick: shift cmd_i in MSB-first and increment the bit counter (8 bits).
  - Last bit index is 47 (short) or 135 (long).
  - When the end bit is sampled, go to CHECK.
- CRC7 (polynomial x^7+x^3+1) coverage:
  - short: bits 47..8.
  - long: bits 127..8 only; bits 135..128 are excluded.
- CHECK (exactly one clk_i cycle):
  - evaluate flags; pulse rx_done_o; go to IDLE.
  - crc_err_o only if check_crc_i.
  - index_err_o only if check_idx_i and not long. Index field is bits 45:40.
  - end_bit_err_o if bit 0 == 0.
- rsp_o mapping:
  - short: rsp_o[31:0] = bits 39:8, upper bits 0.
  - long: rsp_o[119:0] = bits 127:8.
- Transmission bit (46) is not checked.
- Latency: rx_done_o asserts exactly one clk_i cycle after the clk_en_p_i tick that samples the end bit.
- start_rx_i while busy is ignored.
- clk_en_p_i is ignored in CHECK.
- Error flags are sticky until the next accepted arm.

Optional Feature:
Macro: SDHCI_CMD_READ_CRC_OUT_EN.
- Defined: adds output ports crc_rx_o[6:0] (received CRC field) and crc_calc_o[6:0] (computed CRC). Both update in CHECK and hold until the next arm.
- Undefined: these ports and their registers are absent; behaviour is otherwise identical.

Decomposition:
- Package sdhci_pkg holds:
  - the rx state enum;
  - constants RspShortBits = 48, RspLongBits = 136, Crc7Poly = 7'h09.
- One sub-module, crc7_check: serial CRC7 with clear, enable and data-in, and a 7-bit remainder output. It is driven only during the covered bit range.

Test Plan:
- R1 to CMD17: arm (cmd_nr_i = 17, check_crc_i = 1, check_idx_i = 1), drive 0x11 00 00 09 00, CRC 0x33, end bit 1 → rx_done_o pulse, rsp_o[31:0] = 0x00000900, all error flags 0.
- Same frame with CRC 0x32 → crc_err_o = 1, rsp_o still 0x00000900. Repeat with check_crc_i = 0 → crc_err_o = 0.
- cmd_nr_i = 18 against the CMD17 frame → index_err_o = 1. Frame with end bit 0 → end_bit_err_o = 1.
- CMD line held 1 after arm → timeout_err_o = 1 and rx_done_o exactly at the 64th clk_en_p_i tick. Start bit at tick 63 → no timeout.
- R2, 136 bits, with CID payload 0x1234...(random) and valid CRC over bits 127:8 → rsp_o = CID[127:8], no errors.
- rst_ni low mid-RECEIVE → next cycle in IDLE with outputs at reset values; start_rx_i during RECEIVE is ignored.

Source files
------------

// File: rtl/sdhci_pkg.sv
// ---------------------------------------------------------------------------
// sdhci_pkg
// Shared definitions for the SD host CMD-line receive path.
//   rx_state_e   : states of the response receiver FSM
//   RspShortBits : length of an R1/R3/R6/R7 response frame (incl. start/end)
//   RspLongBits  : length of an R2 response frame (incl. start/end)
//   Crc7Poly     : CRC7 generator x^7 + x^3 + 1 (x^7 term implicit)
//   crc7_step    : one serial CRC7 update, MSB-first
// ---------------------------------------------------------------------------
package sdhci_pkg;

  localparam int         RspShortBits = 48;
  localparam int         RspLongBits  = 136;
  localparam logic [6:0] Crc7Poly     = 7'h09;

  typedef enum logic [1:0] {
    RX_IDLE       = 2'd0,
    RX_WAIT_START = 2'd1,
    RX_RECEIVE    = 2'd2,
    RX_CHECK      = 2'd3
  } rx_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
  endfunction

endpackage

// File: rtl/cmd_read_crc7_check.sv
// ---------------------------------------------------------------------------
// crc7_check
// Serial CRC7 accumulator. Bits are folded in MSB-first, one per enabled
// clk_i cycle; clr_i restarts the remainder at zero and wins over en_i.
//   clk_i  : system clock
//   clr_i  : restart remainder
//   en_i   : fold d_i into the remainder this cycle
//   d_i    : serial data bit
//   crc_o  : current 7-bit remainder
// The remainder is datapath state: it is always cleared before use, so it
// carries no reset.
// ---------------------------------------------------------------------------
module crc7_check
  import sdhci_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       d_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      crc_q <= 7'h00;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, d_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cmd_read.sv
// ---------------------------------------------------------------------------
// cmd_read
// SD CMD-line response receiver. Armed by the controller after a command's
// end bit, it waits a bounded number of SD clock ticks for a start bit,
// shifts in a 48-bit or 136-bit response, then checks CRC7, end bit and
// command index in a single CHECK cycle.
//
// Ports
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   clk_en_p_i      : SD clock rising-edge strobe; CMD sampled only here
//   cmd_i           : synchronised CMD line
//   start_rx_i      : arm request (honoured only when idle and not busy)
//   long_rsp_i      : 1 = 136-bit R2, 0 = 48-bit (latched at arm)
//   check_crc_i     : enable CRC7 check (latched at arm)
//   check_idx_i     : enable index check (latched at arm)
//   cmd_nr_i        : expected command index (latched at arm)
//   rsp_o           : payload, short = bits 39:8, long = bits 127:8
//   rx_done_o       : one-cycle end-of-reception pulse
//   busy_o          : high from arm through the rx_done_o pulse
//   timeout_err_o, crc_err_o, end_bit_err_o, index_err_o : sticky flags
//   crc_rx_o, crc_calc_o : received / computed CRC (only with macro
//                          SDHCI_CMD_READ_CRC_OUT_EN defined)
//
// Parameter
//   TimeoutCycles   : SD clock ticks allowed before the start bit (NCR)
// ---------------------------------------------------------------------------
module cmd_read
  import sdhci_pkg::*;
#(
  parameter int TimeoutCycles = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clk_en_p_i,
  input  logic         cmd_i,
  input  logic         start_rx_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  input  logic         check_idx_i,
  input  logic [5:0]   cmd_nr_i,
`ifdef SDHCI_CMD_READ_CRC_OUT_EN
  output logic [6:0]   crc_rx_o,
  output logic [6:0]   crc_calc_o,
`endif
  output logic [119:0] rsp_o,
  output logic         rx_done_o,
  output logic         busy_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o
);

  localparam int ToW = $clog2(TimeoutCycles + 1);

  rx_state_e state_q, state_d;

  // control
  logic [7:0]   bit_cnt_q;
  logic [ToW-1:0] to_cnt_q;
  logic         to_done_q;
  logic         timeout_q, crc_err_q, end_bit_err_q, index_err_q;
  logic [119:0] rsp_q;

  // configuration and datapath (no reset, loaded at arm / during receive)
  logic         long_q, check_crc_q, check_idx_q;
  logic [5:0]   cmd_nr_q;
  logic [127:0] sr_q;
  logic [6:0]   crc_rem;

  logic         accept, start_seen, to_hit, last_bit, in_check;
  logic         crc_en, crc_range;
  logic [7:0]   last_cnt;

  logic         chk_crc_err, chk_end_err, chk_idx_err;
  logic [119:0] rsp_new;

  // A timeout pulse is reported from IDLE, so accept must also wait for it
  // to clear or a new arm could land inside the pulse.
  assign accept     = start_rx_i && (state_q == RX_IDLE) && !to_done_q;
  assign start_seen = clk_en_p_i && (state_q == RX_WAIT_START) && !cmd_i;
  assign to_hit     = clk_en_p_i && (state_q == RX_WAIT_START) && cmd_i &&
                      (to_cnt_q == ToW'(TimeoutCycles - 1));
  assign last_cnt   = long_q ? 8'(RspLongBits - 1) : 8'(RspShortBits - 1);
  assign last_bit   = clk_en_p_i && (state_q == RX_RECEIVE) && (bit_cnt_q == last_cnt);
  assign in_check   = (state_q == RX_CHECK);

  // bit_cnt_q counts bits already taken, so the bit arriving now has frame
  // index (frame_len - 1 - bit_cnt_q). Long responses leave the start bit,
  // transmission bit and reserved field (135..128) out of the CRC.
  assign crc_range = long_q ?
                     ((bit_cnt_q >= 8'(RspLongBits - 128)) && (bit_cnt_q <= 8'(RspLongBits - 9))) :
                     (bit_cnt_q <= 8'(RspShortBits - 9));
  assign crc_en    = clk_en_p_i &&
                     (((state_q == RX_WAIT_START) && !cmd_i && !long_q) ||
                      ((state_q == RX_RECEIVE) && crc_range));

  crc7_check u_crc7 (
    .clk_i (clk_i),
    .clr_i (accept),
    .en_i  (crc_en),
    .d_i   (cmd_i),
    .crc_o (crc_rem)
  );

  // Evaluation in CHECK: sr_q now holds the frame's low 128 bits, end bit
  // in sr_q[0] and received CRC in sr_q[7:1].
  assign chk_crc_err = check_crc_q && (sr_q[7:1] != crc_rem);
  assign chk_end_err = !sr_q[0];
  assign chk_idx_err = check_idx_q && !long_q && (sr_q[45:40] != cmd_nr_q);
  assign rsp_new     = long_q ? sr_q[127:8] : {88'b0, sr_q[39:8]};

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE: begin
        if (accept) state_d = RX_WAIT_START;
      end
      RX_WAIT_START: begin
        if (start_seen)  state_d = RX_RECEIVE;
        else if (to_hit) state_d = RX_IDLE;
      end
      RX_RECEIVE: begin
        if (last_bit) state_d = RX_CHECK;
      end
      RX_CHECK: begin
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: in CHECK the freshly evaluated values are shown alongside the
  // rx_done_o pulse; afterwards the registered copies hold them.
  always_comb begin
    busy_o        = (state_q != RX_IDLE) || to_done_q;
    rx_done_o     = in_check || to_done_q;
    timeout_err_o = timeout_q;
    crc_err_o     = in_check ? chk_crc_err : crc_err_q;
    end_bit_err_o = in_check ? chk_end_err : end_bit_err_q;
    index_err_o   = in_check ? chk_idx_err : index_err_q;
    rsp_o         = in_check ? rsp_new     : rsp_q;
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bit_cnt_q     <= 8'd0;
      to_cnt_q      <= '0;
      to_done_q     <= 1'b0;
      timeout_q     <= 1'b0;
      crc_err_q     <= 1'b0;
      end_bit_err_q <= 1'b0;
      index_err_q   <= 1'b0;
      rsp_q         <= '0;
    end else begin
      to_done_q <= to_hit;
      if (accept) begin
        bit_cnt_q     <= 8'd0;
        to_cnt_q      <= '0;
        timeout_q     <= 1'b0;
        crc_err_q     <= 1'b0;
        end_bit_err_q <= 1'b0;
        index_err_q   <= 1'b0;
      end
      if (start_seen) begin
        bit_cnt_q <= 8'd1;
      end else if (clk_en_p_i && (state_q == RX_WAIT_START)) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
      if (clk_en_p_i && (state_q == RX_RECEIVE)) begin
        bit_cnt_q <= bit_cnt_q + 8'd1;
      end
      if (to_hit) begin
        timeout_q <= 1'b1;
      end
      if (in_check) begin
        crc_err_q     <= chk_crc_err;
        end_bit_err_q <= chk_end_err;
        index_err_q   <= chk_idx_err;
        rsp_q         <= rsp_new;
      end
    end
  end

  // Configuration latch and response shift register
  always_ff @(posedge clk_i) begin
    if (accept) begin
      long_q      <= long_rsp_i;
      check_crc_q <= check_crc_i;
      check_idx_q <= check_idx_i;
      cmd_nr_q    <= cmd_nr_i;
    end
    if (clk_en_p_i && (state_q == RX_RECEIVE)) begin
      sr_q <= {sr_q[126:0], cmd_i};
    end
  end

`ifdef SDHCI_CMD_READ_CRC_OUT_EN
  logic [6:0] crc_rx_q, crc_calc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crc_rx_q   <= 7'h00;
      crc_calc_q <= 7'h00;
    end else if (in_check) begin
      crc_rx_q   <= sr_q[7:1];
      crc_calc_q <= crc_rem;
    end
  end

  assign crc_rx_o   = in_check ? sr_q[7:1] : crc_rx_q;
  assign crc_calc_o = in_check ? crc_rem   : crc_calc_q;
`endif

endmodule

// File: tb/tb_cmd_read.sv
// ---------------------------------------------------------------------------
// tb_cmd_read
// Directed bench for cmd_read. Stimulus pushes the expected outcome of each
// reception into a queue when the last SD tick of that reception is driven;
// a monitor pops and compares every time rx_done_o is seen.
// ---------------------------------------------------------------------------
module tb_cmd_read;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         clk_en_p_i, cmd_i, start_rx_i;
  logic         long_rsp_i, check_crc_i, check_idx_i;
  logic [5:0]   cmd_nr_i;
  logic [119:0] rsp_o;
  logic         rx_done_o, busy_o;
  logic         timeout_err_o, crc_err_o, end_bit_err_o, index_err_o;
`ifdef SDHCI_CMD_READ_CRC_OUT_EN
  logic [6:0]   crc_rx_o, crc_calc_o;
`endif

  cmd_read #(.TimeoutCycles(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clk_en_p_i    (clk_en_p_i),
    .cmd_i         (cmd_i),
    .start_rx_i    (start_rx_i),
    .long_rsp_i    (long_rsp_i),
    .check_crc_i   (check_crc_i),
    .check_idx_i   (check_idx_i),
    .cmd_nr_i      (cmd_nr_i),
`ifdef SDHCI_CMD_READ_CRC_OUT_EN
    .crc_rx_o      (crc_rx_o),
    .crc_calc_o    (crc_calc_o),
`endif
    .rsp_o         (rsp_o),
    .rx_done_o     (rx_done_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o),
    .crc_err_o     (crc_err_o),
    .end_bit_err_o (end_bit_err_o),
    .index_err_o   (index_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] rsp;
    bit           chk_rsp;
    bit           to, crc, eb, idx;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_ni && rx_done_o) begin
      if (done_prev) begin
        fail_now("rx_done_width");
      end else if (sbq.size() == 0) begin
        fail_now("rx_done_unexpected");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle",  128'(cyc),           128'(e.cyc));
        chk("busy_at_done", 128'(busy_o),       128'(1));
        chk("timeout_err", 128'(timeout_err_o), 128'(e.to));
        chk("crc_err",     128'(crc_err_o),     128'(e.crc));
        chk("end_bit_err", 128'(end_bit_err_o), 128'(e.eb));
        chk("index_err",   128'(index_err_o),   128'(e.idx));
        if (e.chk_rsp) chk("rsp", 128'(rsp_o), 128'(e.rsp));
      end
    end
    done_prev = rst_ni ? rx_done_o : 1'b0;
  end

  function automatic exp_t mk(input logic [119:0] rsp, input bit chk_rsp,
                              input bit to, input bit crc, input bit eb, input bit idx);
    exp_t e;
    e.rsp = rsp; e.chk_rsp = chk_rsp; e.to = to; e.crc = crc; e.eb = eb; e.idx = idx;
    e.cyc = 0;
    return e;
  endfunction

  // Reference CRC7 over frame bits hi..lo, MSB first.
  function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] r1(input logic [5:0] idx, input logic [31:0] arg,
                                      input logic [6:0] crc, input logic eb);
    return {88'b0, 2'b00, idx, arg, crc, eb};
  endfunction

  // One SD tick carrying bit b; when last, queue the expected result with
  // rx_done_o due one clk cycle later.
  task automatic tick(input logic b, input bit last, input exp_t e);
    @(negedge clk);
    cmd_i      = b;
    clk_en_p_i = 1'b1;
    if (last) begin
      e.cyc = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    clk_en_p_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [135:0] f, input int hi, input int lo, input exp_t e);
    for (int i = hi; i >= lo; i--) tick(f[i], (i == 0), e);
    cmd_i = 1'b1;
  endtask

  task automatic arm(input logic [5:0] nr, input logic lng, input logic ccrc, input logic cidx);
    @(negedge clk);
    cmd_nr_i    = nr;
    long_rsp_i  = lng;
    check_crc_i = ccrc;
    check_idx_i = cidx;
    start_rx_i  = 1'b1;
    @(negedge clk);
    start_rx_i  = 1'b0;
    chk("busy_after_arm", 128'(busy_o), 128'(1));
  endtask

  logic [135:0] f_ok, f_badcrc, f_badend, f_r2, f_r2bad;
  logic [119:0] cid;
  logic [6:0]   r2crc;

  initial begin
    rst_ni = 1'b0; clk_en_p_i = 1'b0; cmd_i = 1'b1; start_rx_i = 1'b0;
    long_rsp_i = 1'b0; check_crc_i = 1'b0; check_idx_i = 1'b0; cmd_nr_i = 6'd0;

    f_ok     = r1(6'd17, 32'h0000_0900, 7'h33, 1'b1);
    f_badcrc = r1(6'd17, 32'h0000_0900, 7'h32, 1'b1);
    f_badend = r1(6'd17, 32'h0000_0900, 7'h33, 1'b0);
    cid      = 120'h123456789ABCDEF013579BDF02468A;
    f_r2     = {2'b00, 6'h3F, cid, 7'h00, 1'b1};
    r2crc    = crc7_ref(f_r2, 127, 8);
    f_r2[7:1] = r2crc;
    f_r2bad  = f_r2;
    f_r2bad[7:1] = r2crc ^ 7'h01;

    repeat (3) @(negedge clk);
    chk("reset_rsp",     128'(rsp_o),         128'(0));
    chk("reset_busy",    128'(busy_o),        128'(0));
    chk("reset_done",    128'(rx_done_o),     128'(0));
    chk("reset_flags",   128'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}), 128'(0));
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Good R1 to CMD17; a second arm mid-frame must be ignored.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    send(f_ok, 47, 30, mk(120'h900, 1, 0, 0, 0, 0));
    @(negedge clk); start_rx_i = 1'b1; cmd_nr_i = 6'd18; check_crc_i = 1'b0;
    @(negedge clk); start_rx_i = 1'b0;
    send(f_ok, 29, 0, mk(120'h900, 1, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("busy_after_done", 128'(busy_o), 128'(0));

    // Bad CRC, checked; flag must stay up afterwards.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    send(f_badcrc, 47, 0, mk(120'h900, 1, 0, 1, 0, 0));
    repeat (5) @(negedge clk);
    chk("crc_err_sticky", 128'(crc_err_o), 128'(1));

    // Bad CRC, unchecked.
    arm(6'd17, 1'b0, 1'b0, 1'b1);
    send(f_badcrc, 47, 0, mk(120'h900, 1, 0, 0, 0, 0));

    // Index mismatch.
    arm(6'd18, 1'b0, 1'b1, 1'b1);
    send(f_ok, 47, 0, mk(120'h900, 1, 0, 0, 0, 1));

    // End bit 0.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    send(f_badend, 47, 0, mk(120'h900, 1, 0, 0, 1, 0));

    // Timeout: CMD stays high for 64 ticks.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 64; i++) tick(1'b1, (i == 64), mk(120'h0, 0, 1, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("busy_after_timeout", 128'(busy_o), 128'(0));

    // Start bit on tick 63: no timeout.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 62; i++) tick(1'b1, 1'b0, mk(120'h0, 0, 0, 0, 0, 0));
    send(f_ok, 47, 0, mk(120'h900, 1, 0, 0, 0, 0));

    // R2 with valid CRC over bits 127:8; index check must not apply.
    arm(6'd2, 1'b1, 1'b1, 1'b1);
    send(f_r2, 135, 0, mk(cid, 1, 0, 0, 0, 0));

    // R2 with corrupted CRC.
    arm(6'd2, 1'b1, 1'b1, 1'b0);
    send(f_r2bad, 135, 0, mk(cid, 1, 0, 1, 0, 0));

    // Short after long: upper payload bits must return to zero.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    send(f_ok, 47, 0, mk(120'h900, 1, 0, 0, 0, 0));

    // Reset during RECEIVE: no rx_done_o, outputs back to reset values.
    arm(6'd17, 1'b0, 1'b1, 1'b1);
    send(f_ok, 47, 20, mk(120'h0, 0, 0, 0, 0, 0));
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_rsp",   128'(rsp_o),     128'(0));
    chk("midrst_busy",  128'(busy_o),    128'(0));
    chk("midrst_done",  128'(rx_done_o), 128'(0));
    chk("midrst_flags", 128'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}), 128'(0));
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 128'(rx_done_o), 128'(0));

    begin
      int wait_cyc;
      wait_cyc = 0;
      while (sbq.size() != 0 && wait_cyc < 200) begin
        @(negedge clk);
        wait_cyc++;
      end
      chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
